// File: rtl/sqrt_if.sv
// Start/Ack handshake bundle for the square-root accelerator: request side
// (start/operand/mode) and result side (root/remainder/flags).
interface sqrt_if #(
    parameter int WIDTH = 16
);
    logic               start;
    logic [WIDTH-1:0]   operand;
    logic               mode;
    logic [WIDTH/2-1:0] root;
    logic [WIDTH/2:0]   remainder;
    logic               exact;
    logic               busy;
    logic               ack;

    modport master (
        output start, operand, mode,
        input  root, remainder, exact, busy, ack
    );

    modport slave (
        input  start, operand, mode,
        output root, remainder, exact, busy, ack
    );
endinterface

// File: rtl/sqrt_engine.sv
// Integer square root, restoring digit-by-digit, one root bit per clock.
// Floor or round-to-nearest result with optional saturation of the increment.
module sqrt_engine #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input logic   clk,
    input logic   reset,
    sqrt_if.slave bus
);
    localparam int HALF  = WIDTH / 2;
    localparam int REM_W = HALF + 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, ROUND, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [REM_W-1:0] rem_q;
    logic [HALF-1:0]  root_q;
    logic             mode_q;

    logic [REM_W-1:0] rem_shift;
    logic [REM_W-1:0] trial;
    logic             fits;

    // Rounding never ties: (r+0.5)^2 is not an integer, so rem > r decides.
    function automatic logic [HALF-1:0] round_root(input logic [HALF-1:0]  r,
                                                   input logic [REM_W-1:0] rem,
                                                   input logic             m);
        if (m && (rem > REM_W'(r))) begin
            if (SATURATE && (&r))
                return r;
            return r + 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        rem_shift = {rem_q[REM_W-3:0], shift_q[WIDTH-1 -: 2]};
        trial     = {root_q, 2'b01};
        fits      = (rem_shift >= trial);
    end

    // Datapath: operand is captured straight into the shift register on accept.
    always_ff @(posedge clk) begin
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    shift_q <= bus.operand;
                    mode_q  <= bus.mode;
                end
            end
            LOAD: begin
                rem_q  <= '0;
                root_q <= '0;
            end
            CALC: begin
                rem_q   <= fits ? (rem_shift - trial) : rem_shift;
                root_q  <= {root_q[HALF-2:0], fits};
                shift_q <= shift_q << 2;
            end
            default: ;
        endcase
    end

    // Control and result registers; results only move on ROUND -> DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt_q         <= '0;
            bus.busy      <= 1'b0;
            bus.ack       <= 1'b0;
            bus.root      <= '0;
            bus.remainder <= '0;
            bus.exact     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= LOAD;
                        bus.busy <= 1'b1;
                        bus.ack  <= 1'b0;
                    end
                end
                LOAD: begin
                    state <= CALC;
                    cnt_q <= CNT_W'(HALF - 1);
                end
                CALC: begin
                    if (cnt_q == '0)
                        state <= ROUND;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                ROUND: begin
                    state         <= DONE;
                    bus.busy      <= 1'b0;
                    bus.ack       <= 1'b1;
                    bus.root      <= round_root(root_q, rem_q, mode_q);
                    bus.remainder <= rem_q[HALF:0];
                    bus.exact     <= (rem_q == '0);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_engine.sv
// Bench for sqrt_engine: directed corner operands, random sweeps at three
// widths, reset abort, ignored start, and back-to-back restarts.
module tb_sqrt_engine;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sqrt_if #(.WIDTH(16)) if16();
    sqrt_if #(.WIDTH(16)) if16w();
    sqrt_if #(.WIDTH(8))  if8();
    sqrt_if #(.WIDTH(32)) if32();

    assign if16w.start   = if16.start;
    assign if16w.operand = if16.operand;
    assign if16w.mode    = if16.mode;

    sqrt_engine #(.WIDTH(16), .SATURATE(1'b1)) dut16  (.clk(clk), .reset(reset), .bus(if16));
    sqrt_engine #(.WIDTH(16), .SATURATE(1'b0)) dut16w (.clk(clk), .reset(reset), .bus(if16w));
    sqrt_engine #(.WIDTH(8),  .SATURATE(1'b1)) dut8   (.clk(clk), .reset(reset), .bus(if8));
    sqrt_engine #(.WIDTH(32), .SATURATE(1'b1)) dut32  (.clk(clk), .reset(reset), .bus(if32));

    function automatic longint isqrt(input longint x);
        longint r;
        r = longint'($floor($sqrt(real'(x))));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic longint model_root(input longint x, input int half, input bit m, input bit sat);
        longint f;
        longint top;
        f   = isqrt(x);
        top = (longint'(1) << half) - 1;
        if (m && (x - f * f > f)) begin
            if (f == top) return sat ? f : 0;
            return f + 1;
        end
        return f;
    endfunction

    function automatic longint model_rem(input longint x);
        longint f;
        f = isqrt(x);
        return x - f * f;
    endfunction

    task automatic drive(input int w, input bit s, input longint x, input bit m);
        case (w)
            8:  begin if8.start  = s; if8.operand  = x[7:0];  if8.mode  = m; end
            32: begin if32.start = s; if32.operand = x[31:0]; if32.mode = m; end
            default: begin if16.start = s; if16.operand = x[15:0]; if16.mode = m; end
        endcase
    endtask

    task automatic sample(input int w, output longint root, output longint rem,
                          output bit exact, output bit busy, output bit ack);
        case (w)
            8:  begin root = longint'(if8.root);  rem = longint'(if8.remainder);
                      exact = if8.exact;  busy = if8.busy;  ack = if8.ack; end
            32: begin root = longint'(if32.root); rem = longint'(if32.remainder);
                      exact = if32.exact; busy = if32.busy; ack = if32.ack; end
            default: begin root = longint'(if16.root); rem = longint'(if16.remainder);
                      exact = if16.exact; busy = if16.busy; ack = if16.ack; end
        endcase
    endtask

    // Launch one run and wait for Ack; lat counts edges after the accepting edge.
    task automatic do_run(input int w, input longint x, input bit m, output int lat, output bit busy_seen);
        longint r, rm;
        bit ex, bz, ak;
        @(negedge clk);
        drive(w, 1'b1, x, m);
        @(negedge clk);
        drive(w, 1'b0, x, m);
        sample(w, r, rm, ex, bz, ak);
        busy_seen = bz;
        lat = 0;
        while (!ak && lat < 40) begin
            @(negedge clk);
            lat++;
            sample(w, r, rm, ex, bz, ak);
        end
    endtask

    task automatic test_reset();
        longint r, rm;
        bit ex, bz, ak;
        drive(16, 1'b0, 0, 1'b0); drive(8, 1'b0, 0, 1'b0); drive(32, 1'b0, 0, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        sample(16, r, rm, ex, bz, ak);
        checks++; if (r !== 0)   begin errors++; $display("FAIL reset_root got %0d want 0", r); end
        checks++; if (rm !== 0)  begin errors++; $display("FAIL reset_rem got %0d want 0", rm); end
        checks++; if (ex !== 0)  begin errors++; $display("FAIL reset_exact got %0d want 0", ex); end
        checks++; if (bz !== 0)  begin errors++; $display("FAIL reset_busy got %0d want 0", bz); end
        checks++; if (ak !== 0)  begin errors++; $display("FAIL reset_ack got %0d want 0", ak); end
        reset = 1'b1;
    endtask

    task automatic test_directed();
        longint ops [12] = '{81, 80, 80, 72, 65535, 65535, 0, 0, 1, 2, 65280, 65025};
        bit     mds [12] = '{1, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        longint r, rm;
        bit ex, bz, ak, busy_seen;
        int lat;
        for (int i = 0; i < 12; i++) begin
            do_run(16, ops[i], mds[i], lat, busy_seen);
            sample(16, r, rm, ex, bz, ak);
            checks++; if (lat !== 10) begin errors++; $display("FAIL dir_latency op=%0d got %0d want 10", ops[i], lat); end
            checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL dir_busy op=%0d got %0d want 1", ops[i], busy_seen); end
            checks++; if (bz !== 1'b0) begin errors++; $display("FAIL dir_busy_done op=%0d got %0d want 0", ops[i], bz); end
            checks++; if (r !== model_root(ops[i], 8, mds[i], 1'b1))
                begin errors++; $display("FAIL dir_root op=%0d mode=%0d got %0d want %0d", ops[i], mds[i], r, model_root(ops[i], 8, mds[i], 1'b1)); end
            checks++; if (rm !== model_rem(ops[i]))
                begin errors++; $display("FAIL dir_rem op=%0d got %0d want %0d", ops[i], rm, model_rem(ops[i])); end
            checks++; if (ex !== (model_rem(ops[i]) == 0))
                begin errors++; $display("FAIL dir_exact op=%0d got %0d want %0d", ops[i], ex, model_rem(ops[i]) == 0); end
            checks++; if (longint'(if16w.root) !== model_root(ops[i], 8, mds[i], 1'b0))
                begin errors++; $display("FAIL dir_wrap_root op=%0d mode=%0d got %0d want %0d", ops[i], mds[i], if16w.root, model_root(ops[i], 8, mds[i], 1'b0)); end
        end
    endtask

    task automatic test_random(input int w, input int n);
        longint r, rm, x, maxv;
        bit ex, bz, ak, busy_seen, m;
        int lat;
        maxv = (longint'(1) << w) - 1;
        for (int i = 0; i < n; i++) begin
            if (i == 0)      x = 0;
            else if (i == 1) x = maxv;
            else if (w == 32) x = longint'({32'b0, $urandom()});
            else x = longint'($urandom_range(0, 32'(maxv)));
            m = 1'($urandom_range(0, 1));
            if (i < 2) m = 1'b1;
            do_run(w, x, m, lat, busy_seen);
            sample(w, r, rm, ex, bz, ak);
            checks++; if (lat !== w / 2 + 2) begin errors++; $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", w, x, lat, w / 2 + 2); end
            checks++; if (r !== model_root(x, w / 2, m, 1'b1))
                begin errors++; $display("FAIL rnd%0d_root op=%0d mode=%0d got %0d want %0d", w, x, m, r, model_root(x, w / 2, m, 1'b1)); end
            checks++; if (rm !== model_rem(x))
                begin errors++; $display("FAIL rnd%0d_rem op=%0d got %0d want %0d", w, x, rm, model_rem(x)); end
            checks++; if (ex !== (model_rem(x) == 0))
                begin errors++; $display("FAIL rnd%0d_exact op=%0d got %0d want %0d", w, x, ex, model_rem(x) == 0); end
            if (w == 16) begin
                checks++; if (longint'(if16w.root) !== model_root(x, 8, m, 1'b0))
                    begin errors++; $display("FAIL rnd16_wrap_root op=%0d got %0d want %0d", x, if16w.root, model_root(x, 8, m, 1'b0)); end
            end
        end
    endtask

    task automatic test_hold();
        longint r, rm;
        bit ex, bz, ak, busy_seen;
        int lat;
        do_run(16, 200, 1'b0, lat, busy_seen);
        drive(16, 1'b0, 5, 1'b1);
        repeat (3) @(negedge clk);
        sample(16, r, rm, ex, bz, ak);
        checks++; if (r !== 14)  begin errors++; $display("FAIL hold_root got %0d want 14", r); end
        checks++; if (rm !== 4)  begin errors++; $display("FAIL hold_rem got %0d want 4", rm); end
        checks++; if (ak !== 1)  begin errors++; $display("FAIL hold_ack got %0d want 1", ak); end
    endtask

    task automatic test_abort();
        longint r, rm;
        bit ex, bz, ak, busy_seen;
        int lat;
        do_run(16, 50000, 1'b0, lat, busy_seen);
        @(negedge clk); drive(16, 1'b1, 1000, 1'b0);
        @(negedge clk); drive(16, 1'b0, 1000, 1'b0);
        repeat (3) @(negedge clk);
        sample(16, r, rm, ex, bz, ak);
        checks++; if (r !== 223) begin errors++; $display("FAIL abort_prev_root_held got %0d want 223", r); end
        checks++; if (bz !== 1)  begin errors++; $display("FAIL abort_busy_mid got %0d want 1", bz); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sample(16, r, rm, ex, bz, ak);
        checks++; if (r !== 0)  begin errors++; $display("FAIL abort_root got %0d want 0", r); end
        checks++; if (rm !== 0) begin errors++; $display("FAIL abort_rem got %0d want 0", rm); end
        checks++; if (ex !== 0) begin errors++; $display("FAIL abort_exact got %0d want 0", ex); end
        checks++; if (bz !== 0) begin errors++; $display("FAIL abort_busy got %0d want 0", bz); end
        repeat (12) @(negedge clk);
        sample(16, r, rm, ex, bz, ak);
        checks++; if (ak !== 0) begin errors++; $display("FAIL abort_ack_idle got %0d want 0", ak); end
        do_run(16, 1000, 1'b1, lat, busy_seen);
        sample(16, r, rm, ex, bz, ak);
        checks++; if (lat !== 10) begin errors++; $display("FAIL abort_rerun_latency got %0d want 10", lat); end
        checks++; if (r !== 32)   begin errors++; $display("FAIL abort_rerun_root got %0d want 32", r); end
        checks++; if (rm !== 39)  begin errors++; $display("FAIL abort_rerun_rem got %0d want 39", rm); end
    endtask

    task automatic test_ignore_start();
        longint r, rm;
        bit ex, bz, ak;
        int lat;
        @(negedge clk); drive(16, 1'b1, 10000, 1'b0);
        @(negedge clk); drive(16, 1'b0, 10000, 1'b0);
        lat = 0;
        repeat (4) begin @(negedge clk); lat++; end
        drive(16, 1'b1, 300, 1'b1);
        @(negedge clk); lat++;
        drive(16, 1'b0, 300, 1'b1);
        sample(16, r, rm, ex, bz, ak);
        while (!ak && lat < 40) begin
            @(negedge clk);
            lat++;
            sample(16, r, rm, ex, bz, ak);
        end
        checks++; if (lat !== 10) begin errors++; $display("FAIL ignore_latency got %0d want 10", lat); end
        checks++; if (r !== 100)  begin errors++; $display("FAIL ignore_root got %0d want 100", r); end
        checks++; if (rm !== 0)   begin errors++; $display("FAIL ignore_rem got %0d want 0", rm); end
        checks++; if (ex !== 1)   begin errors++; $display("FAIL ignore_exact got %0d want 1", ex); end
    endtask

    task automatic test_back_to_back();
        longint r, rm;
        bit ex, bz, ak, busy_seen;
        int lat;
        @(negedge clk); drive(16, 1'b1, 4097, 1'b1);
        @(negedge clk);
        lat = 0;
        sample(16, r, rm, ex, bz, ak);
        while (!ak && lat < 40) begin
            @(negedge clk);
            lat++;
            sample(16, r, rm, ex, bz, ak);
        end
        checks++; if (lat !== 10) begin errors++; $display("FAIL b2b_first_latency got %0d want 10", lat); end
        checks++; if (r !== 64)   begin errors++; $display("FAIL b2b_first_root got %0d want 64", r); end
        drive(16, 1'b1, 12345, 1'b1);
        @(negedge clk);
        sample(16, r, rm, ex, bz, ak);
        checks++; if (ak !== 0) begin errors++; $display("FAIL b2b_ack_one_cycle got %0d want 0", ak); end
        busy_seen = bz;
        checks++; if (busy_seen !== 1) begin errors++; $display("FAIL b2b_restart_busy got %0d want 1", busy_seen); end
        lat = 0;
        while (!ak && lat < 40) begin
            @(negedge clk);
            lat++;
            sample(16, r, rm, ex, bz, ak);
        end
        drive(16, 1'b0, 12345, 1'b1);
        checks++; if (lat !== 10) begin errors++; $display("FAIL b2b_second_latency got %0d want 10", lat); end
        checks++; if (r !== model_root(12345, 8, 1'b1, 1'b1))
            begin errors++; $display("FAIL b2b_second_root got %0d want %0d", r, model_root(12345, 8, 1'b1, 1'b1)); end
        checks++; if (rm !== model_rem(12345))
            begin errors++; $display("FAIL b2b_second_rem got %0d want %0d", rm, model_rem(12345)); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random(16, 400);
        test_random(8, 200);
        test_random(32, 120);
        test_abort();
        test_ignore_start();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
